// File: rtl/kr580_uart_port.sv
// ---------------------------------------------------------------------------
// kr580_uart_port
//   8N1 UART peripheral that the kr580 CPU reaches through its I/O port space.
//   Four consecutive ports starting at BASE give access to:
//     +0  read: RX FIFO head (no pop)     write: TX holding register
//     +1  read: status {frame_err, tx_ie, rx_ie, tx_busy,
//                       tx_ready, rx_overrun, rx_full, rx_nonempty}
//     +2  write: bit0 pops the RX FIFO, bit7 clears the sticky error flags
//     +3  read/write: interrupt enables {tx_ie, rx_ie} in bits 1:0
//   The bytes it receives go into a small FIFO. The bytes it transmits go
//   through a one-byte holding register into a shift register.
//
// Ports
//   clk       CPU clock, all logic on the rising edge
//   reset     synchronous, active-high
//   pin_pa    I/O port address
//   pin_po    I/O write data
//   pin_pw    I/O write strobe, one clk per OUT
//   pin_pi    I/O read data, combinational, 8'h00 when not addressed so
//             several peripherals can be OR-merged onto the CPU input bus
//   pin_intr  registered level interrupt request
//   uart_rx   asynchronous serial input, idle high
//   uart_tx   registered serial output, idle high
// ---------------------------------------------------------------------------
module kr580_uart_port #(
  parameter logic [7:0] BASE    = 8'h10,
  parameter int         DIVISOR = 54,
  parameter int         FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pin_pa,
  input  logic [7:0] pin_po,
  input  logic       pin_pw,
  output logic [7:0] pin_pi,
  output logic       pin_intr,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0]        DIV_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0]        HALF_LAST = 16'(DIVISOR / 2 - 1);
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // -------------------------------------------------------------------------
  // Address decode. The subtraction wraps addresses below BASE to large
  // values, so one range test covers both sides of the window.
  // -------------------------------------------------------------------------
  logic [7:0] offset;
  logic       sel;
  logic       wr_data;
  logic       wr_ctrl;
  logic       wr_ie;

  assign offset  = pin_pa - BASE;
  assign sel     = (offset[7:2] == 6'd0);
  assign wr_data = pin_pw && sel && (offset[1:0] == 2'd0);
  assign wr_ctrl = pin_pw && sel && (offset[1:0] == 2'd2);
  assign wr_ie   = pin_pw && sel && (offset[1:0] == 2'd3);

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic [7:0]  hold_data;
  logic        hold_full;
  logic        tx_ready;
  logic        tx_busy;

  assign tx_ready = ~hold_full;
  assign tx_busy  = (tx_state != ST_IDLE);

  // uart_tx changes together with the state, so each state drives the line
  // for exactly DIVISOR clocks. A write while the holding register is full
  // is dropped. The write and the transfer to the shifter cannot both hit
  // hold_full in the same clock: one needs it empty and the other needs it
  // full.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= 16'd0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      uart_tx   <= 1'b1;
    end else begin
      if (wr_data && !hold_full) begin
        hold_data <= pin_po;
        hold_full <= 1'b1;
      end
      case (tx_state)
        ST_IDLE: begin
          if (hold_full) begin
            tx_shift  <= hold_data;
            hold_full <= 1'b0;
            tx_cnt    <= 16'd0;
            tx_state  <= ST_START;
            uart_tx   <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_state <= ST_DATA;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= 16'd0;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_tx  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          // Stop bit. A byte that is already waiting starts at once, so
          // there is no idle bit between frames.
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= 16'd0;
            if (hold_full) begin
              tx_shift  <= hold_data;
              hold_full <= 1'b0;
              tx_state  <= ST_START;
              uart_tx   <= 1'b0;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Receiver: two-flop synchroniser, then an extra flop for edge detection.
  // -------------------------------------------------------------------------
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_push;
  logic [7:0]  rx_byte;
  logic        frame_err;
  logic        clr_err;

  assign clr_err = wr_ctrl && pin_po[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // The start bit is checked half a bit after the falling edge. That rejects
  // short glitches and places every later sample near the middle of its bit.
  // A finished byte is handed to the FIFO as a one-clock rx_push pulse. A new
  // frame error wins over a clear that arrives in the same clock, so the
  // error is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state  <= ST_IDLE;
      rx_cnt    <= 16'd0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
      rx_push   <= 1'b0;
      rx_byte   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (clr_err) begin
        frame_err <= 1'b0;
      end
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= 16'd0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= 16'd0;
            rx_bit <= 3'd0;
            if (!rx_s2) begin
              rx_state <= ST_DATA;
            end else begin
              rx_state <= ST_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= 16'd0;
            rx_state <= ST_IDLE;
            if (rx_s2) begin
              rx_push <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               rx_nonempty;
  logic               rx_full;
  logic               rx_overrun;
  logic               pop_ok;
  logic               push_ok;
  logic [7:0]         rx_head;

  assign rx_nonempty = (count != '0);
  assign rx_full     = (count == DEPTH_CNT);
  assign pop_ok      = wr_ctrl && pin_po[0] && rx_nonempty;
  // A pop in the same clock frees a slot first, so a push into a full FIFO
  // still succeeds.
  assign push_ok     = rx_push && (!rx_full || pop_ok);
  assign rx_head     = rx_nonempty ? fifo_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= rx_byte;
    end
  end

  // A push that cannot be stored sets the sticky overrun flag. As with
  // frame_err, a new overrun wins over a clear in the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      if (clr_err) begin
        rx_overrun <= 1'b0;
      end
      if (rx_push && !push_ok) begin
        rx_overrun <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt enables and the registered interrupt request
  // -------------------------------------------------------------------------
  logic rx_ie;
  logic tx_ie;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
    end else if (wr_ie) begin
      rx_ie <= pin_po[0];
      tx_ie <= pin_po[1];
    end
  end

  // The TX request waits until the line is fully idle, not just until the
  // holding register is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_intr <= 1'b0;
    end else begin
      pin_intr <= (rx_ie && rx_nonempty) || (tx_ie && tx_ready && !tx_busy);
    end
  end

  // -------------------------------------------------------------------------
  // Read mux. Write-only ports and unselected addresses return zero.
  // -------------------------------------------------------------------------
  logic [7:0] status;

  assign status = {frame_err, tx_ie, rx_ie, tx_busy,
                   tx_ready, rx_overrun, rx_full, rx_nonempty};

  always_comb begin
    pin_pi = 8'h00;
    if (sel) begin
      case (offset[1:0])
        2'd0:    pin_pi = rx_head;
        2'd1:    pin_pi = status;
        2'd3:    pin_pi = {6'b0, tx_ie, rx_ie};
        default: pin_pi = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_kr580_uart_port.sv
// ---------------------------------------------------------------------------
// tb_kr580_uart_port
//   Directed bench for kr580_uart_port with DIVISOR=4 and BASE=8'h10.
//   Inputs change on the falling clock edge. Outputs are read just after the
//   falling edge, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_kr580_uart_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pin_pa;
  logic [7:0] pin_po;
  logic       pin_pw;
  logic [7:0] pin_pi;
  logic       pin_intr;
  logic       uart_rx;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kr580_uart_port #(
    .BASE    (8'h10),
    .DIVISOR (4),
    .FIFO_AW (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pin_pa   (pin_pa),
    .pin_po   (pin_po),
    .pin_pw   (pin_pw),
    .pin_pi   (pin_pi),
    .pin_intr (pin_intr),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx)
  );

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // A single-clock OUT strobe. Returns on the falling edge just after the
  // rising edge that took the write.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    pin_pa = addr;
    pin_po = data;
    pin_pw = 1'b1;
    @(negedge clk);
    pin_pw = 1'b0;
  endtask

  // A combinational read. It does not wait for any clock edge.
  task automatic read_port(input logic [7:0] addr, output logic [7:0] data);
    pin_pa = addr;
    #1;
    data = pin_pi;
  endtask

  // One 8N1 frame. Each bit lasts 4 clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Expected uart_tx k falling edges after the write of 55h. The write of
  // AAh lands during the first frame, so AAh follows straight after 55h.
  function automatic logic tx_exp(input int k);
    logic [7:0] first;
    logic [7:0] second;
    first  = 8'h55;
    second = 8'hAA;
    if (k <= 4)  return 1'b0;
    if (k <= 36) return first[(k - 5) / 4];
    if (k <= 40) return 1'b1;
    if (k <= 44) return 1'b0;
    if (k <= 76) return second[(k - 45) / 4];
    return 1'b1;
  endfunction

  // Stops the run if the stimulus stalls for any reason.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    int n;

    reset   = 1'b1;
    pin_pa  = 8'h00;
    pin_po  = 8'h00;
    pin_pw  = 1'b0;
    uart_rx = 1'b1;

    // Reset state after one clock of reset.
    @(negedge clk);
    checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset_intr", 32'(pin_intr), 32'd0);
    read_port(8'h11, rd);
    checkOutput("reset_status", 32'(rd), 32'h08);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    read_port(8'h20, rd);
    checkOutput("unselected_read", 32'(rd), 32'h00);
    read_port(8'h12, rd);
    checkOutput("port12_read", 32'(rd), 32'h00);

    // TX: 55h, then AAh queued during the first frame.
    applyStimulus(8'h10, 8'h55);
    checkOutput("tx_line_before_start", 32'(uart_tx), 32'd1);
    read_port(8'h11, rd);
    checkOutput("tx_status_holding", 32'(rd), 32'h00);
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      if (k == 3) pin_pw = 1'b0;
      read_port(8'h11, rd);
      checkOutput($sformatf("tx_line_k%0d", k), 32'(uart_tx), 32'(tx_exp(k)));
      checkOutput($sformatf("tx_busy_k%0d", k), 32'(rd[4]), 32'(k <= 80));
      if (k == 2) begin
        pin_pa = 8'h10;
        pin_po = 8'hAA;
        pin_pw = 1'b1;
      end
    end

    // RX: one frame, then a pop.
    send_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    read_port(8'h11, rd);
    checkOutput("rx_status_one", 32'(rd), 32'h09);
    read_port(8'h10, rd);
    checkOutput("rx_head_a3", 32'(rd), 32'hA3);
    applyStimulus(8'h12, 8'h01);
    read_port(8'h11, rd);
    checkOutput("rx_status_popped", 32'(rd), 32'h08);

    // Fill the FIFO and overflow it by one byte.
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    read_port(8'h11, rd);
    checkOutput("fifo_full_overrun", 32'(rd), 32'h0F);
    for (int i = 0; i < 16; i++) begin
      read_port(8'h10, rd);
      checkOutput($sformatf("fifo_pop_%0d", i), 32'(rd), 32'(i));
      applyStimulus(8'h12, 8'h01);
    end
    read_port(8'h11, rd);
    checkOutput("fifo_drained", 32'(rd), 32'h0C);
    read_port(8'h10, rd);
    checkOutput("fifo_empty_head", 32'(rd), 32'h00);
    applyStimulus(8'h12, 8'h80);
    read_port(8'h11, rd);
    checkOutput("overrun_cleared", 32'(rd), 32'h08);

    // One-clock glitch on the line.
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    read_port(8'h11, rd);
    checkOutput("glitch_ignored", 32'(rd), 32'h08);

    // Frame with a bad stop bit.
    send_frame(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    read_port(8'h11, rd);
    checkOutput("frame_err_status", 32'(rd), 32'h88);
    read_port(8'h10, rd);
    checkOutput("frame_err_no_push", 32'(rd), 32'h00);
    applyStimulus(8'h12, 8'h80);
    read_port(8'h11, rd);
    checkOutput("frame_err_cleared", 32'(rd), 32'h08);

    // Writes to addresses outside the window.
    applyStimulus(8'h14, 8'h03);
    applyStimulus(8'h0F, 8'h03);
    read_port(8'h13, rd);
    checkOutput("oob_write_ignored", 32'(rd), 32'h00);
    checkOutput("oob_no_intr", 32'(pin_intr), 32'd0);

    // Interrupt enables while the UART is idle.
    applyStimulus(8'h13, 8'h03);
    checkOutput("intr_latency_0", 32'(pin_intr), 32'd0);
    @(negedge clk);
    checkOutput("intr_asserted", 32'(pin_intr), 32'd1);
    read_port(8'h11, rd);
    checkOutput("ie_status", 32'(rd), 32'h68);
    read_port(8'h13, rd);
    checkOutput("ie_readback", 32'(rd), 32'h03);

    // With only tx_ie set, the request drops during a frame and returns
    // after the stop bit.
    applyStimulus(8'h13, 8'h02);
    applyStimulus(8'h10, 8'h3C);
    @(negedge clk);
    checkOutput("intr_drop", 32'(pin_intr), 32'd0);
    repeat (19) @(negedge clk);
    read_port(8'h11, rd);
    checkOutput("intr_mid_frame", 32'(pin_intr), 32'd0);
    checkOutput("busy_mid_frame", 32'(rd[4]), 32'd1);
    n = 20;
    while (!pin_intr && n < 80) begin
      @(negedge clk);
      n++;
    end
    checkOutput("intr_reassert_cycle", 32'(n), 32'd42);
    read_port(8'h11, rd);
    checkOutput("intr_reassert_status", 32'(rd), 32'h48);

    // Reset in the middle of a frame.
    applyStimulus(8'h10, 8'h00);
    repeat (10) @(negedge clk);
    checkOutput("tx_low_before_reset", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("midreset_intr", 32'(pin_intr), 32'd0);
    read_port(8'h11, rd);
    checkOutput("midreset_status", 32'(rd), 32'h08);
    read_port(8'h13, rd);
    checkOutput("midreset_ie", 32'(rd), 32'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("after_reset_idle", 32'(uart_tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
